// File: rtl/an_decoder.sv
// an_decoder: single-error-correcting AN-code decoder, A = 47.
// Receives a 23-bit arithmetic codeword X = 47*N +/- 2^k. The decoder takes the
// syndrome R = X mod 47, maps R to the error bit k and its sign, corrects X,
// and divides by 47 to recover N. The decode is combinational and the
// outputs are registered, so latency is 1 cycle and throughput is 1 word/cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   numX is valid this cycle
//   numX       received codeword (23 bits, unsigned)
//   out        decoded data word N (17 bits); 0 when range_err
//   out_valid  out and the flags hold a fresh decode
//   err_flag   nonzero syndrome, so a correction was applied
//   err_pos    corrected bit position k (0 when no error)
//   err_sign   0: received value was +2^k too high, 1: it was -2^k too low
//   range_err  corrected value negative or quotient above 17 bits
module an_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [22:0] numX,
  output logic [16:0] out,
  output logic        out_valid,
  output logic        err_flag,
  output logic [4:0]  err_pos,
  output logic        err_sign,
  output logic        range_err
);

  localparam int unsigned A    = 47;
  localparam int unsigned CW_W = 23;
  localparam int unsigned D_W  = 17;

  logic [5:0]         syn;
  logic [5:0]         pr;
  logic [24:0]        pw;
  logic               c_flag;
  logic [4:0]         c_pos;
  logic               c_sign;
  logic signed [24:0] xc;
  logic [24:0]        q;
  logic               c_range;
  logic [D_W-1:0]     c_out;

  always_comb begin
    syn    = 6'(numX % 23'(A));
    c_flag = 1'b0;
    c_pos  = '0;
    c_sign = 1'b0;
    pr     = '0;
    pw     = '0;
    xc     = $signed({2'b00, numX});
    // 2^k mod 47 has order 23, so for k = 0..22 the residues 2^k and
    // 47 - 2^k cover 1..46 exactly once; every nonzero syndrome hits one entry.
    for (int unsigned k = 0; k < CW_W; k++) begin
      pr = 6'((25'd1 << k) % 25'(A));
      if (syn == pr) begin
        c_flag = 1'b1;
        c_pos  = 5'(k);
        c_sign = 1'b0;
        pw     = 25'd1 << k;
        xc     = $signed({2'b00, numX}) - $signed(pw);
      end else if (syn == 6'(A) - pr) begin
        c_flag = 1'b1;
        c_pos  = 5'(k);
        c_sign = 1'b1;
        pw     = 25'd1 << k;
        xc     = $signed({2'b00, numX}) + $signed(pw);
      end
    end
    q       = 25'(xc) / 25'(A);
    c_range = xc[24] || (q > 25'((1 << D_W) - 1));
    c_out   = c_range ? '0 : q[D_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err_flag  <= 1'b0;
      err_pos   <= '0;
      err_sign  <= 1'b0;
      range_err <= 1'b0;
    end else if (in_valid) begin
      out       <= c_out;
      out_valid <= 1'b1;
      err_flag  <= c_flag;
      err_pos   <= c_pos;
      err_sign  <= c_sign;
      range_err <= c_range;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_an_decoder.sv
module tb_an_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [22:0] numX;
  logic [16:0] out;
  logic        out_valid;
  logic        err_flag;
  logic [4:0]  err_pos;
  logic        err_sign;
  logic        range_err;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  an_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .numX      (numX),
    .out       (out),
    .out_valid (out_valid),
    .err_flag  (err_flag),
    .err_pos   (err_pos),
    .err_sign  (err_sign),
    .range_err (range_err)
  );

  // Reference decode: find the single power of two whose removal or addition
  // makes the value a multiple of 47, then divide.
  function automatic void decode(input longint x, output logic [16:0] o,
                                 output logic ef, output logic [4:0] ep,
                                 output logic es, output logic re);
    longint xc;
    longint p;
    xc = x;
    ef = 1'b0;
    ep = '0;
    es = 1'b0;
    if (x % 47 != 0) begin
      for (int k = 0; k < 23; k++) begin
        p = longint'(1) << k;
        if ((x - p) % 47 == 0) begin
          xc = x - p; ef = 1'b1; ep = 5'(k); es = 1'b0;
        end else if ((x + p) % 47 == 0) begin
          xc = x + p; ef = 1'b1; ep = 5'(k); es = 1'b1;
        end
      end
    end
    re = (xc < 0) || (xc / 47 > 131071);
    o  = re ? 17'd0 : 17'(xc / 47);
  endfunction

  // Model of the registered outputs.
  logic [16:0] m_out;
  logic        m_valid, m_ef, m_es, m_re;
  logic [4:0]  m_ep;
  logic [16:0] t_o;
  logic        t_ef, t_es, t_re;
  logic [4:0]  t_ep;

  always @(posedge clk) begin
    if (rst) begin
      m_out <= '0; m_valid <= 1'b0; m_ef <= 1'b0; m_ep <= '0; m_es <= 1'b0; m_re <= 1'b0;
    end else if (in_valid) begin
      decode(longint'(numX), t_o, t_ef, t_ep, t_es, t_re);
      m_out <= t_o; m_valid <= 1'b1; m_ef <= t_ef; m_ep <= t_ep; m_es <= t_es; m_re <= t_re;
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out !== m_out || out_valid !== m_valid || err_flag !== m_ef ||
          err_pos !== m_ep || err_sign !== m_es || range_err !== m_re) begin
        failures++;
        $display("FAIL model_cmp t=%0t got out=%0d v=%0b ef=%0b ep=%0d es=%0b re=%0b need out=%0d v=%0b ef=%0b ep=%0d es=%0b re=%0b",
                 $time, out, out_valid, err_flag, err_pos, err_sign, range_err,
                 m_out, m_valid, m_ef, m_ep, m_es, m_re);
      end
    end
  end

  task automatic step(input logic v, input logic [22:0] x);
    in_valid = v;
    numX     = x;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [16:0] o, input logic v,
                     input logic ef, input logic [4:0] ep, input logic es,
                     input logic re);
    checks++;
    if (out !== o || out_valid !== v || err_flag !== ef || err_pos !== ep ||
        err_sign !== es || range_err !== re) begin
      failures++;
      $display("FAIL %s got out=%0d v=%0b ef=%0b ep=%0d es=%0b re=%0b need out=%0d v=%0b ef=%0b ep=%0d es=%0b re=%0b",
               name, out, out_valid, err_flag, err_pos, err_sign, range_err,
               o, v, ef, ep, es, re);
    end
  endtask

  initial begin
    longint x;
    rst = 1'b1;
    step(1'b1, 23'd63121);
    step(1'b1, 23'd63121);
    lit("reset", 17'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;

    step(1'b1, 23'd63121);
    lit("clean_1343", 17'd1343, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 23'd0);
    lit("clean_zero", 17'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    for (int k = 0; k < 23; k++) begin
      step(1'b1, 23'(63121 + (1 << k)));
      lit($sformatf("pos_k%0d", k), 17'd1343, 1'b1, 1'b1, 5'(k), 1'b0, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 23'(63121 - (1 << k)));
      lit($sformatf("neg_k%0d", k), 17'd1343, 1'b1, 1'b1, 5'(k), 1'b1, 1'b0);
    end

    step(1'b1, 23'd1);
    lit("one", 17'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 23'd6160384);
    lit("quot_ovf", 17'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 23'd4194257);
    lit("neg_corr", 17'd0, 1'b1, 1'b1, 5'd22, 1'b0, 1'b1);

    step(1'b1, 23'd63121);
    step(1'b0, 23'd5);
    lit("gap_hold", 17'd1343, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    step(1'b1, 23'd47 * 23'd7 + 23'd8);
    lit("pre_rst", 17'd7, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 23'd63122);
    lit("mid_rst", 17'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 23'd63120);
    lit("post_rst", 17'd1343, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      x = longint'($urandom_range(0, 178481)) * 47;
      case ($urandom_range(0, 3))
        0: x = x + (longint'(1) << $urandom_range(0, 22));
        1: x = x - (longint'(1) << $urandom_range(0, 22));
        2: x = longint'($urandom_range(0, 8388607));
        default: ;
      endcase
      if (x < 0 || x > 8388607) x = longint'($urandom_range(0, 8388607));
      rst = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 3) != 0), 23'(x));
    end
    rst = 1'b0;
    step(1'b0, 23'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
